// File: rtl/game_layer_compositor.sv
// Sprite layer compositor: fixed-priority merge over a background, 2-stage pipeline,
// per-frame collision flag and a blinking end-of-game overlay.
module game_layer_compositor #(
  parameter int unsigned N_SPRITES    = 8,
  parameter int unsigned RGB_W        = 3,
  parameter int unsigned END_FRAMES   = 120,
  parameter int unsigned BLINK_FRAMES = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_pix_valid,
  input  logic                         i_frame_start,
  input  logic [N_SPRITES-1:0]         i_spr_en,
  input  logic [N_SPRITES*RGB_W-1:0]   i_spr_rgb,
  input  logic [N_SPRITES-1:0]         i_layer_mask,
  input  logic [RGB_W-1:0]             i_bg_rgb,
  input  logic                         i_end_start,
  input  logic                         i_game_won,
  input  logic                         i_random,
  output logic [RGB_W-1:0]             o_rgb,
  output logic                         o_rgb_valid,
  output logic                         o_collision,
  output logic                         o_end_busy
);

  localparam int unsigned FCNT_W = $clog2(END_FRAMES + 1);
  localparam int unsigned BCNT_W = $clog2(BLINK_FRAMES + 1);

  typedef enum logic {ST_IDLE, ST_FLASH} state_t;

  logic [N_SPRITES-1:0] w_vis;
  logic [RGB_W-1:0]     w_win_rgb;
  logic                 w_multi;
  logic [RGB_W-1:0]     r_s1_rgb;
  logic                 r_s1_any;
  logic                 r_s1_multi;
  logic                 r_s1_valid;
  logic                 w_s1_hit;
  logic                 r_sticky;

  state_t               r_state, w_state_nxt;
  logic [FCNT_W-1:0]    r_fcnt, w_fcnt_nxt;
  logic [BCNT_W-1:0]    r_bcnt, w_bcnt_nxt;
  logic                 r_phase, w_phase_nxt;
  logic                 r_won, w_won_nxt;
  logic                 w_ovl_on;
  logic [RGB_W-1:0]     w_ovl_rgb;

  assign w_vis   = i_spr_en & i_layer_mask;
  // At least two bits set: clearing the lowest set bit leaves something behind.
  assign w_multi = |(w_vis & (w_vis - N_SPRITES'(1)));

  // Highest-priority (lowest index) visible layer, else background.
  always_comb begin
    w_win_rgb = i_bg_rgb;
    for (int i = int'(N_SPRITES) - 1; i >= 0; i--) begin
      if (w_vis[i]) w_win_rgb = i_spr_rgb[i*RGB_W +: RGB_W];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_rgb   <= '0;
      r_s1_any   <= 1'b0;
      r_s1_multi <= 1'b0;
      r_s1_valid <= 1'b0;
    end else begin
      r_s1_rgb   <= w_win_rgb;
      r_s1_any   <= |w_vis;
      r_s1_multi <= w_multi;
      r_s1_valid <= i_pix_valid;
    end
  end

  assign w_s1_hit = r_s1_valid & r_s1_any & r_s1_multi;

  // Collision accumulates over a frame and is published at the next frame start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sticky    <= 1'b0;
      o_collision <= 1'b0;
    end else if (i_frame_start) begin
      o_collision <= r_sticky | w_s1_hit;
      r_sticky    <= 1'b0;
    end else if (w_s1_hit) begin
      r_sticky    <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_fcnt     <= '0;
      r_bcnt     <= '0;
      r_phase    <= 1'b0;
      r_won      <= 1'b0;
      o_end_busy <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_fcnt     <= w_fcnt_nxt;
      r_bcnt     <= w_bcnt_nxt;
      r_phase    <= w_phase_nxt;
      r_won      <= w_won_nxt;
      o_end_busy <= (w_state_nxt == ST_FLASH);
    end
  end

  // end_start takes precedence over frame counting, including a coincident frame_start.
  always_comb begin
    w_state_nxt = r_state;
    w_fcnt_nxt  = r_fcnt;
    w_bcnt_nxt  = r_bcnt;
    w_phase_nxt = r_phase;
    w_won_nxt   = r_won;
    if (i_end_start) begin
      w_state_nxt = ST_FLASH;
      w_won_nxt   = i_game_won;
      w_fcnt_nxt  = '0;
      w_bcnt_nxt  = '0;
      w_phase_nxt = 1'b1;
    end else if ((r_state == ST_FLASH) && i_frame_start) begin
      if (r_fcnt == FCNT_W'(END_FRAMES - 1)) begin
        w_state_nxt = ST_IDLE;
        w_phase_nxt = 1'b0;
      end else begin
        w_fcnt_nxt = r_fcnt + FCNT_W'(1);
        if (r_bcnt == BCNT_W'(BLINK_FRAMES - 1)) begin
          w_phase_nxt = ~r_phase;
          w_bcnt_nxt  = '0;
        end else begin
          w_bcnt_nxt = r_bcnt + BCNT_W'(1);
        end
      end
    end
  end

  assign w_ovl_on = (r_state == ST_FLASH) & r_phase;

  always_comb begin
    w_ovl_rgb            = '0;
    w_ovl_rgb[RGB_W-1]   = 1'b1;
    w_ovl_rgb[RGB_W-2]   = ~r_won;
    w_ovl_rgb[RGB_W-3]   = i_random;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_rgb       <= '0;
      o_rgb_valid <= 1'b0;
    end else begin
      o_rgb_valid <= r_s1_valid;
      if (!r_s1_valid)   o_rgb <= '0;
      else if (w_ovl_on) o_rgb <= w_ovl_rgb;
      else               o_rgb <= r_s1_rgb;
    end
  end

endmodule

// File: tb/tb_game_layer_compositor.sv
// Scoreboard bench for game_layer_compositor: random pixels/frames against a frame-level
// reference model; a separate monitor pops expected pixels as the DUT presents them.
module tb_game_layer_compositor;

  localparam int unsigned N     = 8;
  localparam int unsigned W     = 3;
  localparam int unsigned END   = 4;
  localparam int unsigned BLINK = 2;

  typedef struct {
    logic         pv, fs, es, won, rnd;
    logic [N-1:0] en, mask;
    logic [N*W-1:0] srgb;
    logic [W-1:0] bg;
  } stim_t;

  typedef struct {
    logic [W-1:0] rgb;
    int           due;
  } exp_t;

  logic           clk, rst;
  logic           pix_valid, frame_start, end_start, game_won, random_bit;
  logic [N-1:0]   spr_en, layer_mask;
  logic [N*W-1:0] spr_rgb;
  logic [W-1:0]   bg_rgb, rgb;
  logic           rgb_valid, collision, end_busy;

  game_layer_compositor #(.N_SPRITES(N), .RGB_W(W), .END_FRAMES(END), .BLINK_FRAMES(BLINK)) dut (
    .clk(clk), .rst(rst),
    .i_pix_valid(pix_valid), .i_frame_start(frame_start),
    .i_spr_en(spr_en), .i_spr_rgb(spr_rgb), .i_layer_mask(layer_mask), .i_bg_rgb(bg_rgb),
    .i_end_start(end_start), .i_game_won(game_won), .i_random(random_bit),
    .o_rgb(rgb), .o_rgb_valid(rgb_valid), .o_collision(collision), .o_end_busy(end_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  exp_t q[$];

  // Reference model state, frame-level view of the design.
  logic         p_valid;
  logic [W-1:0] p_rgb;
  logic         m_frame_hit, m_coll, m_active, m_won;
  int           m_k;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [W-1:0] ref_pixel(input stim_t s);
    logic [N-1:0] vis;
    vis = s.en & s.mask;
    for (int i = 0; i < int'(N); i++) if (vis[i]) return s.srgb[i*W +: W];
    return s.bg;
  endfunction

  function automatic stim_t idle_stim();
    stim_t s;
    s = '{pv: 1'b0, fs: 1'b0, es: 1'b0, won: 1'b0, rnd: 1'b0,
          en: '0, mask: '0, srgb: '0, bg: '0};
    return s;
  endfunction

  function automatic stim_t rand_stim(input int mode);
    stim_t s;
    int idx;
    s      = idle_stim();
    s.pv   = ($urandom_range(0, 3) != 0);
    s.mask = N'($urandom | $urandom);
    if (mode == 0) begin
      idx  = $urandom_range(0, N);
      s.en = (idx == int'(N)) ? '0 : N'(1) << idx;
    end else begin
      s.en = N'($urandom & $urandom);
    end
    s.srgb = (N*W)'($urandom);
    s.bg   = W'($urandom);
    s.rnd  = 1'($urandom);
    s.won  = 1'($urandom);
    return s;
  endfunction

  task automatic apply(input stim_t s);
    pix_valid   = s.pv;   frame_start = s.fs;   end_start  = s.es;
    game_won    = s.won;  random_bit  = s.rnd;  spr_en     = s.en;
    layer_mask  = s.mask; spr_rgb     = s.srgb; bg_rgb     = s.bg;
  endtask

  task automatic model_clear();
    p_valid = 1'b0; p_rgb = '0;
    m_frame_hit = 1'b0; m_coll = 1'b0; m_active = 1'b0; m_won = 1'b0; m_k = 0;
    q.delete();
  endtask

  // One clock: check status outputs, drive inputs, advance the model across the next edge.
  task automatic step(input stim_t s);
    logic multi;
    logic ovl;
    @(negedge clk);
    check("collision", int'(collision), int'(m_coll));
    check("end_busy", int'(end_busy), int'(m_active));
    apply(s);
    if (p_valid) begin
      ovl = m_active && (((m_k / int'(BLINK)) % 2) == 0);
      q.push_back('{rgb: ovl ? {1'b1, ~m_won, s.rnd} : p_rgb, due: cyc + 1});
    end
    multi = ($countones(s.en & s.mask) >= 2);
    if (s.fs) begin
      m_coll      = m_frame_hit;
      m_frame_hit = s.pv && multi;
    end else if (s.pv && multi) begin
      m_frame_hit = 1'b1;
    end
    if (s.es) begin
      m_active = 1'b1; m_k = 0; m_won = s.won;
    end else if (s.fs && m_active) begin
      m_k++;
      if (m_k == int'(END)) m_active = 1'b0;
    end
    p_valid = s.pv;
    p_rgb   = ref_pixel(s);
  endtask

  // Asynchronous reset between edges; outputs must clear without waiting for a clock.
  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_end_busy", int'(end_busy), 0);
    check("rst_rgb", int'(rgb), 0);
    check("rst_rgb_valid", int'(rgb_valid), 0);
    check("rst_collision", int'(collision), 0);
    apply(idle_stim());
    model_clear();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_frames(input int nf);
    stim_t s;
    int    len, mode;
    for (int f = 0; f < nf; f++) begin
      mode = $urandom_range(0, 1);
      len  = $urandom_range(8, 16);
      for (int c = 0; c < len; c++) begin
        s    = rand_stim(mode);
        s.fs = (c == 0);
        s.es = ($urandom_range(0, 39) == 0);
        step(s);
      end
    end
  endtask

  task automatic flash_frames(input int nf, input int len);
    stim_t s;
    for (int f = 0; f < nf; f++) begin
      for (int c = 0; c < len; c++) begin
        s    = rand_stim(1);
        s.pv = 1'b1;
        s.fs = (c == 0);
        step(s);
      end
    end
  endtask

  // Monitor: pops the scoreboard whenever a valid pixel appears.
  always @(posedge clk) begin
    exp_t e;
    cyc = cyc + 1;
    #1;
    if (!rst) begin
      if (rgb_valid) begin
        if (q.size() == 0) begin
          check("unexpected_valid", 1, 0);
        end else begin
          e = q.pop_front();
          check("rgb", int'(rgb), int'(e.rgb));
          check("latency", cyc, e.due);
        end
      end else begin
        check("blank_rgb", int'(rgb), 0);
      end
    end
  end

  initial begin
    stim_t s;
    logic [N*W-1:0] sr;
    rst = 1'b1;
    apply(idle_stim());
    model_clear();
    #1;
    check("reset_rgb", int'(rgb), 0);
    check("reset_rgb_valid", int'(rgb_valid), 0);
    check("reset_collision", int'(collision), 0);
    check("reset_end_busy", int'(end_busy), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Priority: sprites 5 and 2 visible, sprite 2 wins.
    s = idle_stim(); s.fs = 1'b1; s.pv = 1'b1; s.mask = '1;
    s.en = 8'b0010_0100; sr = (N*W)'($urandom); sr[2*W +: W] = 3'b011; s.srgb = sr;
    step(s);
    // Nothing visible shows the background.
    s = idle_stim(); s.pv = 1'b1; s.mask = '1; s.bg = 3'b001; step(s);
    // Masked sprite shows the background.
    s = idle_stim(); s.pv = 1'b1; s.en = 8'h01; s.mask = 8'h00; s.bg = 3'b110;
    s.srgb = '1; step(s);
    // Blanking.
    s = idle_stim(); s.pv = 1'b0; s.en = 8'h01; s.mask = 8'hff; s.srgb = '1; step(s);
    // Collision in frame k, none in frame k+1.
    s = idle_stim(); s.pv = 1'b1; s.en = 8'h03; s.mask = 8'hff; step(s);
    for (int i = 0; i < 4; i++) step(idle_stim());
    s = idle_stim(); s.fs = 1'b1; s.pv = 1'b1; s.en = 8'h01; s.mask = '1; step(s);
    for (int i = 0; i < 6; i++) step(idle_stim());
    s = idle_stim(); s.fs = 1'b1; step(s);
    for (int i = 0; i < 6; i++) step(idle_stim());

    // Overlay: end_start with frame_start, game lost, then the whole sequence.
    s = rand_stim(1); s.pv = 1'b1; s.fs = 1'b1; s.es = 1'b1; s.won = 1'b0; step(s);
    for (int c = 1; c < 6; c++) begin s = rand_stim(1); s.pv = 1'b1; step(s); end
    flash_frames(5, 6);

    // Restart mid-flash on a coincident frame_start.
    s = rand_stim(1); s.fs = 1'b1; s.es = 1'b1; s.won = 1'b1; step(s);
    flash_frames(2, 6);
    s = rand_stim(1); s.fs = 1'b1; s.es = 1'b1; s.won = 1'b0; step(s);
    for (int c = 1; c < 6; c++) begin s = rand_stim(1); s.pv = 1'b1; step(s); end
    flash_frames(1, 6);
    s = rand_stim(1); s.pv = 1'b1; s.fs = 1'b1; step(s);
    s = rand_stim(1); s.pv = 1'b1; s.en = 8'h03; s.mask = '1; step(s);
    do_reset();

    run_frames(150);
    do_reset();
    run_frames(20);

    for (int i = 0; i < 4; i++) step(idle_stim());
    check("scoreboard_empty", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
